// File: rtl/can_clic_seq.sv
// Interrupt arbiter: bit-serial MSB-first wired-OR arbitration over enabled, pending entries above threshold.
// Latency: 1 snapshot edge + NR_PRIO_BITS+NR_INDEX_BITS arbitration edges from a sampled pending bit to irq_valid.
// Backpressure: a winner is held on irq_valid until irq_ready claims it, or until it stops qualifying.
module can_clic_seq #(
  parameter int NR_INDEX_BITS = 3,
  parameter int NR_PRIO_BITS  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2**NR_INDEX_BITS-1:0] set_pending,
  input  logic                        cfg_we,
  input  logic [NR_INDEX_BITS-1:0]    cfg_idx,
  input  logic                        cfg_en,
  input  logic [NR_PRIO_BITS-1:0]     cfg_prio,
  input  logic [NR_PRIO_BITS-1:0]     threshold,
  output logic                        irq_valid,
  output logic [NR_INDEX_BITS-1:0]    irq_index,
  output logic [NR_PRIO_BITS-1:0]     irq_prio,
  input  logic                        irq_ready,
  output logic                        busy
);

  localparam int N  = 2**NR_INDEX_BITS;
  localparam int KW = NR_PRIO_BITS + NR_INDEX_BITS;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;

  state_t                  state, state_nxt;
  logic [N-1:0]            en, pending;
  logic [NR_PRIO_BITS-1:0] prio      [N];
  logic [NR_PRIO_BITS-1:0] snap_prio [N];
  logic [N-1:0]            snap_mask, mask_nxt, contender, arb_bit, clr;
  logic [CW-1:0]           bit_cnt;
  logic                    or_value, withdraw;
  logic [NR_INDEX_BITS-1:0] win_idx;

  // Live contender set from the current enable/pending/priority registers.
  always_comb begin
    contender = '0;
    for (int i = 0; i < N; i++)
      contender[i] = en[i] & pending[i] & (prio[i] > threshold);
  end

  // Current arbitration bit per entry, survivor update and surviving index.
  always_comb begin
    logic [KW-1:0] key;
    key     = '0;
    arb_bit = '0;
    for (int i = 0; i < N; i++) begin
      key        = {snap_prio[i], NR_INDEX_BITS'(i)};
      arb_bit[i] = key[bit_cnt];
    end
    or_value = |(snap_mask & arb_bit);
    mask_nxt = or_value ? (snap_mask & arb_bit) : snap_mask;
    win_idx  = '0;
    for (int i = 0; i < N; i++)
      if (mask_nxt[i]) win_idx = NR_INDEX_BITS'(i);
  end

  // Presented winner stops qualifying when disabled or pushed to/below threshold.
  always_comb begin
    withdraw = ~en[irq_index] | (prio[irq_index] <= threshold);
    clr      = '0;
    if (state == PRESENT && irq_ready) clr[irq_index] = 1'b1;
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    irq_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    if (|contender) state_nxt = ARB;
      ARB: begin
        busy = 1'b1;
        if (bit_cnt == '0) state_nxt = PRESENT;
      end
      PRESENT: begin
        irq_valid = 1'b1;
        if (irq_ready || withdraw) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Snapshot at round start, shrink survivors per bit, latch the winner on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_mask <= '0;
      bit_cnt   <= '0;
      irq_index <= '0;
      irq_prio  <= '0;
      for (int i = 0; i < N; i++) snap_prio[i] <= '0;
    end else if (state == IDLE && |contender) begin
      snap_mask <= contender;
      bit_cnt   <= CW'(KW - 1);
      for (int i = 0; i < N; i++) snap_prio[i] <= prio[i];
    end else if (state == ARB) begin
      snap_mask <= mask_nxt;
      bit_cnt   <= bit_cnt - CW'(1);
      if (bit_cnt == '0) begin
        irq_index <= win_idx;
        irq_prio  <= snap_prio[win_idx];
      end
    end
  end

  // Pending set/clear (set beats a same-edge claim) and configuration writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      pending <= '0;
      for (int i = 0; i < N; i++) prio[i] <= '0;
    end else begin
      pending <= set_pending | (pending & ~clr);
      if (cfg_we) begin
        en[cfg_idx]   <= cfg_en;
        prio[cfg_idx] <= cfg_prio;
      end
    end
  end

  // Index bits are unique, so the last arbitration bit must leave a single survivor.
  always_ff @(posedge clk) begin
    if (rst_n && state == ARB && bit_cnt == '0)
      assert ($onehot(mask_nxt));
  end

endmodule
